// File: rtl/fnd_scan.sv
// fnd_scan: frame-latched 4-digit common-anode FND scanner with active-low seg/com, one-cycle registered output latency and no backpressure.
// Define FND_BLINK_EN to blink digit 3 every BLINK_FRAMES frames.
module fnd_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] pswd0,
    input  logic [3:0] pswd1,
    input  logic [3:0] pswd2,
    input  logic [3:0] correct,
    output logic [7:0] seg,
    output logic [3:0] com,
    output logic       frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);

    if (SCAN_DIV < 4 || GUARD < 1 || GUARD >= SCAN_DIV || BLINK_FRAMES < 1) begin : g_bad_param
        $error("fnd_scan: illegal parameter combination");
    end

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    sh [4];
    logic          tick;
    logic          load;
    logic          blank_d3;

    assign tick = (cnt == CW'(SCAN_DIV - 1));
    assign load = tick && (idx == 2'd3);

    function automatic logic [7:0] decode(input logic [3:0] code);
        logic [7:0] s;
        case (code)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'hFF;
            4'hB:    s = 8'h89;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

`ifdef FND_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] fcnt;
    logic          phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (load) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // A blank result code stays blank rather than blinking.
    assign blank_d3 = phase && (sh[3] != 4'hA) && (idx == 2'd3);
`else
    assign blank_d3 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            frame_tick <= 1'b0;
            seg        <= 8'hFF;
            com        <= 4'hF;
            for (int k = 0; k < 4; k++) sh[k] <= 4'hA;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            frame_tick <= load;
            if (tick) idx <= idx + 2'd1;
            if (load) begin
                sh[0] <= pswd0;
                sh[1] <= pswd1;
                sh[2] <= pswd2;
                sh[3] <= correct;
            end
            // Leading guard cycles keep all digits dark so the previous pattern does not ghost.
            if (cnt < CW'(GUARD)) begin
                com <= 4'hF;
                seg <= 8'hFF;
            end else begin
                com <= ~(4'b0001 << idx);
                seg <= blank_d3 ? 8'hFF : decode(sh[idx]);
            end
        end
    end

endmodule
